// File: rtl/kgp_decode_execute_stage.sv
// KGP-RISC decode/execute stage: IF/ID pipeline register, field decoder,
// ALU operand selector and a 32-bit ALU with carry/zero/sign flags.
module kgp_decode_execute_stage #(
    parameter int DATA_W = 32,
    parameter int PC_W   = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic [DATA_W-1:0] instr_in,
    input  logic [PC_W-1:0]   npc_in,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] rt_data,
    output logic [DATA_W-1:0] instr,
    output logic [PC_W-1:0]   npc,
    output logic [2:0]        opcode,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic [4:0]        shamt,
    output logic [3:0]        func,
    output logic [21:0]       imm,
    output logic [24:0]       label,
    output logic              mem_write,
    output logic [DATA_W-1:0] alu_out,
    output logic              carry_flag,
    output logic              zero_flag,
    output logic              sign_flag
);

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_ADDI  = 3'b001;
    localparam logic [2:0] OP_COMPI = 3'b010;
    localparam logic [2:0] OP_LW    = 3'b011;
    localparam logic [2:0] OP_SW    = 3'b100;

    localparam logic [3:0] F_ADD    = 4'b0000;
    localparam logic [3:0] F_COMP   = 4'b0001;
    localparam logic [3:0] F_AND    = 4'b0010;
    localparam logic [3:0] F_XOR    = 4'b0011;
    localparam logic [3:0] F_SHLL_I = 4'b0100;
    localparam logic [3:0] F_SHRL_I = 4'b0101;
    localparam logic [3:0] F_SHLL_R = 4'b0110;
    localparam logic [3:0] F_SHRL_R = 4'b0111;
    localparam logic [3:0] F_SHRA_I = 4'b1000;
    localparam logic [3:0] F_SHRA_R = 4'b1001;

    // IF/ID register; a flush or reset loads instruction 0, which is the NOP.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr <= '0;
            npc   <= '0;
        end else if (flush) begin
            instr <= '0;
            npc   <= '0;
        end else begin
            instr <= instr_in;
            npc   <= npc_in;
        end
    end

    assign opcode    = instr[31:29];
    assign rs_addr   = instr[28:24];
    assign rt_addr   = instr[23:19];
    assign shamt     = instr[18:14];
    assign func      = instr[3:0];
    assign imm       = instr[21:0];
    assign label     = instr[24:0];
    assign mem_write = (opcode == OP_SW);

    logic [DATA_W-1:0] input1;
    logic [DATA_W-1:0] input2;
    logic [DATA_W-1:0] imm_sext;
    logic              shamt_sel;

    assign input1    = rs_data;
    assign imm_sext  = {{(DATA_W-22){imm[21]}}, imm};
    assign shamt_sel = (func == F_SHLL_I) || (func == F_SHRL_I) || (func == F_SHRA_I);

    always_comb begin
        input2 = rt_data;
        case (opcode)
            OP_ALU: begin
                if (shamt_sel) begin
                    input2 = {{(DATA_W-5){1'b0}}, shamt};
                end
            end
            OP_ADDI, OP_COMPI, OP_LW, OP_SW: input2 = imm_sext;
            default: input2 = rt_data;
        endcase
    end

    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   neg_ext;
    logic [4:0]        sh_amt;
    logic [DATA_W-1:0] sra_res;

    // Carry is bit 32 of the widened sum / two's-complement negation.
    assign sum_ext = {1'b0, input1} + {1'b0, input2};
    assign neg_ext = {1'b0, ~input2} + {{DATA_W{1'b0}}, 1'b1};
    assign sh_amt  = input2[4:0];
    assign sra_res = $unsigned($signed(input1) >>> sh_amt);

    always_comb begin
        alu_out    = '0;
        carry_flag = 1'b0;
        case (opcode)
            OP_ALU: begin
                case (func)
                    F_ADD: begin
                        alu_out    = sum_ext[DATA_W-1:0];
                        carry_flag = sum_ext[DATA_W];
                    end
                    F_COMP: begin
                        alu_out    = neg_ext[DATA_W-1:0];
                        carry_flag = neg_ext[DATA_W];
                    end
                    F_AND:              alu_out = input1 & input2;
                    F_XOR:              alu_out = input1 ^ input2;
                    F_SHLL_I, F_SHLL_R: alu_out = input1 << sh_amt;
                    F_SHRL_I, F_SHRL_R: alu_out = input1 >> sh_amt;
                    F_SHRA_I, F_SHRA_R: alu_out = sra_res;
                    default:            alu_out = '0;
                endcase
            end
            OP_ADDI, OP_LW, OP_SW: begin
                alu_out    = sum_ext[DATA_W-1:0];
                carry_flag = sum_ext[DATA_W];
            end
            OP_COMPI: begin
                alu_out    = neg_ext[DATA_W-1:0];
                carry_flag = neg_ext[DATA_W];
            end
            // Branches and jumps pass rs through for the zero/sign tests.
            default: alu_out = input1;
        endcase
    end

    assign zero_flag = (alu_out == '0);
    assign sign_flag = alu_out[DATA_W-1];

endmodule

// File: tb/tb_kgp_decode_execute_stage.sv
// Bench for kgp_decode_execute_stage: directed cases plus random instructions
// compared against an arithmetic reference model.
module tb_kgp_decode_execute_stage;

    logic        clk;
    logic        reset;
    logic        flush;
    logic [31:0] instr_in;
    logic [9:0]  npc_in;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] instr;
    logic [9:0]  npc;
    logic [2:0]  opcode;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [4:0]  shamt;
    logic [3:0]  func;
    logic [21:0] imm;
    logic [24:0] label;
    logic        mem_write;
    logic [31:0] alu_out;
    logic        carry_flag;
    logic        zero_flag;
    logic        sign_flag;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q[$];
    logic [9:0]  exp_npc_q[$];

    kgp_decode_execute_stage dut (
        .clk(clk), .reset(reset), .flush(flush),
        .instr_in(instr_in), .npc_in(npc_in),
        .rs_data(rs_data), .rt_data(rt_data),
        .instr(instr), .npc(npc), .opcode(opcode),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .shamt(shamt),
        .func(func), .imm(imm), .label(label), .mem_write(mem_write),
        .alu_out(alu_out), .carry_flag(carry_flag),
        .zero_flag(zero_flag), .sign_flag(sign_flag)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference ALU: works on plain integers, using the instruction-set rules.
    function automatic void ref_alu(input logic [31:0] ins, input logic [31:0] rs,
                                    input logic [31:0] rt,
                                    output logic [31:0] res, output logic cy);
        longint unsigned op, fn, sh, iv, b, a, t, full;
        longint          simm;
        full = 64'h1_0000_0000;
        a    = rs;
        op   = (ins >> 29) & 7;
        fn   = ins & 15;
        sh   = (ins >> 14) & 31;
        iv   = ins & 64'h3F_FFFF;
        simm = (iv >= 64'h20_0000) ? longint'(iv) - 64'sh40_0000 : longint'(iv);
        if (op >= 1 && op <= 4)
            b = longint'(simm) & (full - 1);
        else if (op == 0 && (fn == 4 || fn == 5 || fn == 8))
            b = sh;
        else
            b = rt;
        t  = 0;
        cy = 1'b0;
        if (op == 1 || op == 3 || op == 4 || (op == 0 && fn == 0)) begin
            t  = a + b;
            cy = (t >= full);
        end else if (op == 2 || (op == 0 && fn == 1)) begin
            t  = (full - 1 - b) + 1;
            cy = (t >= full);
        end else if (op == 0) begin
            case (fn)
                2:       t = a & b;
                3:       t = a ^ b;
                4, 6:    t = (a << (b % 32)) & (full - 1);
                5, 7:    t = a >> (b % 32);
                8, 9:    t = longint'($signed(int'(a)) >>> (b % 32));
                default: t = 0;
            endcase
        end else begin
            t = a;
        end
        res = t[31:0];
    endfunction

    task automatic check_outputs(input string tag);
        logic [31:0] ei;
        logic [9:0]  en;
        logic [31:0] eres;
        logic        ecy;
        ei = exp_q.pop_front();
        en = exp_npc_q.pop_front();
        ref_alu(ei, rs_data, rt_data, eres, ecy);
        check_val({tag, ".instr"}, instr, ei);
        check_val({tag, ".npc"}, npc, en);
        check_val({tag, ".fields"},
                  {opcode, rs_addr, rt_addr, shamt, func, imm, label},
                  {ei[31:29], ei[28:24], ei[23:19], ei[18:14], ei[3:0], ei[21:0], ei[24:0]});
        check_val({tag, ".mem_write"}, mem_write, ((ei >> 29) == 4));
        check_val({tag, ".alu_out"}, alu_out, eres);
        check_val({tag, ".carry"}, carry_flag, ecy);
        check_val({tag, ".zero"}, zero_flag, (eres == 0));
        check_val({tag, ".sign"}, sign_flag, (eres >= 32'h8000_0000));
    endtask

    // driver: apply one instruction, clock it in, then check the stage outputs
    task automatic step(input string tag, input logic [31:0] ins, input logic [9:0] np,
                        input logic fl, input logic [31:0] rs, input logic [31:0] rt);
        @(negedge clk);
        instr_in = ins;
        npc_in   = np;
        flush    = fl;
        rs_data  = rs;
        rt_data  = rt;
        exp_q.push_back(fl ? 32'h0 : ins);
        exp_npc_q.push_back(fl ? 10'h0 : np);
        @(posedge clk);
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [31:0] mk_r(input logic [2:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [4:0] sh,
                                         input logic [3:0] fn);
        return {op, rs, rt, sh, 10'h0, fn};
    endfunction

    function automatic logic [31:0] mk_i(input logic [2:0] op, input logic [4:0] rs,
                                         input logic [21:0] iv);
        return {op, rs, 2'b00, iv};
    endfunction

    initial begin
        logic [31:0] ins;
        logic [31:0] rs;
        logic [31:0] rt;
        reset    = 1'b0;
        flush    = 1'b0;
        instr_in = 32'h0;
        npc_in   = 10'h0;
        rs_data  = 32'h0;
        rt_data  = 32'h0;
        #2;
        reset = 1'b1;
        #1;
        check_val("rst.instr", instr, 0);
        check_val("rst.npc", npc, 0);
        check_val("rst.opcode", opcode, 0);
        check_val("rst.mem_write", mem_write, 0);

        // directed cases
        step("add", 32'h0A18_0000, 10'd5, 1'b0, 32'hFFFF_FFFF, 32'h1);
        check_val("add.rs_addr", rs_addr, 10);
        check_val("add.rt_addr", rt_addr, 3);
        check_val("add.res", {alu_out, carry_flag, zero_flag}, {32'h0, 1'b1, 1'b1});
        step("shra", mk_r(3'b000, 5'd1, 5'd2, 5'd4, 4'b1000), 10'd6, 1'b0, 32'h8000_0000, 32'h0);
        check_val("shra.res", {alu_out, sign_flag}, {32'hF800_0000, 1'b1});
        step("addi", mk_i(3'b001, 5'd4, 22'h3F_FFFF), 10'd7, 1'b0, 32'd10, 32'h0);
        check_val("addi.res", {alu_out, carry_flag}, {32'd9, 1'b1});
        step("sw", mk_i(3'b100, 5'd4, 22'h10), 10'd8, 1'b0, 32'h100, 32'h0);
        check_val("sw.mem_write", mem_write, 1);
        step("comp5", mk_r(3'b000, 5'd0, 5'd5, 5'd0, 4'b0001), 10'd9, 1'b0, 32'h0, 32'd5);
        check_val("comp5.res", {alu_out, sign_flag}, {32'hFFFF_FFFB, 1'b1});
        step("comp0", mk_r(3'b000, 5'd0, 5'd5, 5'd0, 4'b0001), 10'd10, 1'b0, 32'h0, 32'd0);
        check_val("comp0.res", {alu_out, carry_flag}, {32'h0, 1'b1});
        step("shll32", mk_r(3'b000, 5'd1, 5'd2, 5'd0, 4'b0110), 10'd11, 1'b0, 32'h1234_5678, 32'd32);
        check_val("shll32.res", alu_out, 32'h1234_5678);
        step("flush", 32'h2345_6789, 10'd12, 1'b1, 32'd3, 32'd4);
        check_val("flush.instr", instr, 0);

        // async reset between edges
        step("pre_rst", mk_r(3'b111, 5'd7, 5'd8, 5'd0, 4'h0), 10'd13, 1'b0, 32'd20, 32'd22);
        #1;
        reset = 1'b0;
        #1;
        check_val("arst.instr", instr, 0);
        check_val("arst.npc", npc, 0);
        check_val("arst.alu_out", alu_out, 32'd42);
        #1;
        reset = 1'b1;

        // random instructions
        for (int i = 0; i < 300; i++) begin
            ins = $urandom;
            if ($urandom_range(0, 1) == 1) ins[3:0] = 4'($urandom_range(0, 9));
            case ($urandom_range(0, 5))
                0:       rs = 32'h0;
                1:       rs = 32'hFFFF_FFFF;
                2:       rs = 32'h8000_0000;
                default: rs = $urandom;
            endcase
            case ($urandom_range(0, 4))
                0:       rt = 32'h0;
                1:       rt = 32'($urandom_range(0, 40));
                default: rt = $urandom;
            endcase
            step("rand", ins, 10'($urandom), ($urandom_range(0, 7) == 0), rs, rt);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
